ptp_int_svc: RTL and testbench
==============================

PTP_INT_SVC -- requirements
Module: ptp_int_svc

Interface
REQ-001 Parameter INT_BASE_ADDR, default 32'h300, meaning: address of the interrupt status register; the mask register is at INT_BASE_ADDR+1.
REQ-002 Parameter MASK_INIT, default 4'b1111, meaning: mask value written once after reset.
REQ-003 Parameter HOLDOFF, default 6, meaning: minimum cycles after a status read before the next status read may start; range 1..15.
REQ-004 Ports: bus2ip_clk  in  1  single clock, all logic on its rising edge.
REQ-005 Ports: bus2ip_rst  in  1  reset, synchronous, active-high.
REQ-006 Ports: int_ptp_i  in  1  combined interrupt level from the interrupt controller.
REQ-007 Ports: svc_en_i  in  1  service enable; level.
REQ-008 Ports: bus2ip_data_i  in  32  read data returned combinationally by the slave while ip2bus_rd_ce_o=1.
REQ-009 Ports: ip2bus_addr_o  out  32  bus address; 0 when no strobe is active.
REQ-010 Ports: ip2bus_data_o  out  32  write data; 0 when ip2bus_wr_ce_o=0.
REQ-011 Ports: ip2bus_rd_ce_o / ip2bus_wr_ce_o  out  1 each  read and write strobes, active high, never both high.
REQ-012 Ports: mask_i  in  4  new mask value; mask_wr_i  in  1  one-cycle request to write mask_i.
REQ-013 Ports: evt_valid_o  out  1, evt_src_o  out  2, evt_ready_i  in  1  event handshake; src 3=rx_all, 2=xms, 1=rx_ptp, 0=tx_ptp.
REQ-014 Ports: busy_o  out  1  high whenever the state is not IDLE; spur_cnt_o  out  8, evt_cnt_o  out  16  statistics.

Function
REQ-015 States SHALL be INIT_WR, IDLE, MASK_WR, RD_STAT and DISPATCH; all registered outputs SHALL change only on the bus2ip_clk edge.
REQ-016 INIT_WR SHALL last one cycle, with wr_ce=1, addr=INT_BASE_ADDR+1 and data={28'b0,MASK_INIT}, then go to IDLE.
REQ-017 mask_wr_i=1 in any state SHALL capture mask_i into mask_q and set mask_pend; a later request overwrites mask_q (latest wins).
REQ-018 IDLE priority SHALL be: mask_pend -> MASK_WR; else int_ptp_i=1 and svc_en_i=1 -> RD_STAT; else remain in IDLE.
REQ-019 MASK_WR SHALL last one cycle, with wr_ce=1, addr=INT_BASE_ADDR+1 and data={28'b0,mask_q}; it SHALL clear mask_pend unless mask_wr_i is asserted in the same cycle, then go to IDLE.
REQ-020 RD_STAT SHALL last one cycle with rd_ce=1 and addr=INT_BASE_ADDR; it SHALL load pending[3:0]<=bus2ip_data_i[3:0] and hold_cnt<=HOLDOFF, then go to DISPATCH.
REQ-021 In DISPATCH both strobes SHALL be 0; hold_cnt SHALL decrement each cycle and saturate at 0.
REQ-022 In DISPATCH, evt_valid_o SHALL equal |pending, and evt_src_o SHALL be the index of the highest set pending bit (3 has highest priority).
REQ-023 While evt_valid_o=1 and evt_ready_i=0, evt_valid_o and evt_src_o SHALL remain stable.
REQ-024 On evt_valid_o & evt_ready_i, the indicated pending bit SHALL clear; consecutive events SHALL be issuable on back-to-back cycles.
REQ-025 DISPATCH SHALL exit to IDLE in the cycle where pending (after that cycle's clear) is 0 and hold_cnt is 0.
REQ-026 A status read returning 0 in bits [3:0] SHALL produce no events and SHALL count as spurious.
REQ-027 svc_en_i=0 SHALL block only new RD_STAT entries; a sequence already in progress SHALL complete.
REQ-028 Outside DISPATCH, evt_valid_o SHALL be 0 and evt_src_o SHALL be 0.

Reset
REQ-029 While bus2ip_rst=1, the state SHALL be INIT_WR-pending and all outputs 0, including strobes, evt_valid_o, busy_o and counters; pending, mask_q, mask_pend and hold_cnt SHALL be 0.
REQ-030 The first cycle after bus2ip_rst falls SHALL be INIT_WR; reset asserted mid-sequence SHALL abort it, drop all outputs at the next edge and discard pending events.

Configuration
REQ-031 With PTP_INT_SVC_STAT_EN defined: spur_cnt_o SHALL increment per spurious read and saturate at 255, and evt_cnt_o SHALL increment per accepted event and wrap at 65535.
REQ-032 Without PTP_INT_SVC_STAT_EN: spur_cnt_o and evt_cnt_o SHALL be tied to 0, no counter registers SHALL exist, and the ports SHALL remain present.

Verification
REQ-033 Reset release -> exactly one cycle wr_ce=1, addr=32'h301, data=32'h0000000F; then busy_o=0 and the strobes stay 0.
REQ-034 int_ptp_i=1, read data 32'h9, evt_ready_i=1 -> one rd_ce cycle at 32'h300; events src=3 then src=0 on consecutive cycles; busy_o falls 6 cycles after RD_STAT.
REQ-035 Read data 32'h2, evt_ready_i low for 5 cycles -> evt_valid_o=1 and evt_src_o=1 held for 5 cycles; accepted on the 6th cycle.
REQ-036 mask_wr_i with mask_i=4'h5 during DISPATCH while int_ptp_i stays 1 -> after IDLE, a wr_ce to 32'h301 with data 32'h5 precedes the next rd_ce.
REQ-037 Read data 32'h0 -> no evt_valid_o; spur_cnt_o=1 with PTP_INT_SVC_STAT_EN defined, 0 without.
REQ-038 bus2ip_rst=1 during DISPATCH with pending 4'hC -> evt_valid_o=0 at the next edge; after release, INIT_WR repeats and no stale events are issued.

Source files
------------

// File: rtl/ptp_int_svc.sv
// ptp_int_svc: services the combined PTP interrupt line. After reset it writes
// the initial mask, then reads the status register on each interrupt, issues one
// event per set status bit (highest index first) and holds off before re-reading.
// Optional statistics counters are enabled by defining PTP_INT_SVC_STAT_EN.
// All outputs are registered. They are computed from the next state, so each
// output value appears in the same cycle as the state it belongs to.
module ptp_int_svc #(
    parameter logic [31:0] INT_BASE_ADDR = 32'h300,
    parameter logic [3:0]  MASK_INIT     = 4'b1111,
    parameter int unsigned HOLDOFF       = 6
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst,
    input  logic        int_ptp_i,
    input  logic        svc_en_i,
    input  logic [31:0] bus2ip_data_i,
    output logic [31:0] ip2bus_addr_o,
    output logic [31:0] ip2bus_data_o,
    output logic        ip2bus_rd_ce_o,
    output logic        ip2bus_wr_ce_o,
    input  logic [3:0]  mask_i,
    input  logic        mask_wr_i,
    output logic        evt_valid_o,
    output logic [1:0]  evt_src_o,
    input  logic        evt_ready_i,
    output logic        busy_o,
    output logic [7:0]  spur_cnt_o,
    output logic [15:0] evt_cnt_o
);

    typedef enum logic [2:0] {
        ST_INIT_WR,
        ST_IDLE,
        ST_MASK_WR,
        ST_RD_STAT,
        ST_DISPATCH
    } state_t;

    localparam logic [31:0] MASK_ADDR = INT_BASE_ADDR + 32'd1;
    localparam logic [3:0]  HOLD_LD   = 4'(HOLDOFF);

    state_t      state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  hold_q, hold_d;
    logic [3:0]  mask_q, mask_d;
    logic        mask_pend_q, mask_pend_d;
    // Reset parks the FSM in IDLE with this flag set, so the initial mask write
    // takes precedence over everything on the first cycle out of reset.
    logic        init_pend_q, init_pend_d;
    logic        spur_hit;
    logic        evt_acc;

    logic        rd_ce_q, wr_ce_q, evt_valid_q, busy_q;
    logic [31:0] addr_q, data_q;
    logic [1:0]  evt_src_q;

    // Only the low nibble of the status word carries interrupt sources.
    logic unused_data;
    assign unused_data = ^bus2ip_data_i[31:4];

    function automatic logic [1:0] prio(input logic [3:0] p);
        if (p[3])      return 2'd3;
        else if (p[2]) return 2'd2;
        else if (p[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    // Next-state, pending-event and mask bookkeeping.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        hold_d      = hold_q;
        mask_d      = mask_q;
        mask_pend_d = mask_pend_q;
        init_pend_d = init_pend_q;
        spur_hit    = 1'b0;
        evt_acc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_pend_q)                 state_d = ST_INIT_WR;
                else if (mask_pend_q)            state_d = ST_MASK_WR;
                else if (int_ptp_i && svc_en_i)  state_d = ST_RD_STAT;
            end
            ST_INIT_WR: begin
                init_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end
            ST_MASK_WR: begin
                mask_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end
            ST_RD_STAT: begin
                pending_d = bus2ip_data_i[3:0];
                hold_d    = HOLD_LD;
                spur_hit  = (bus2ip_data_i[3:0] == 4'd0);
                state_d   = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                hold_d = (hold_q != 4'd0) ? hold_q - 4'd1 : 4'd0;
                if (evt_valid_q && evt_ready_i) begin
                    evt_acc              = 1'b1;
                    pending_d[evt_src_q] = 1'b0;
                end
                // Leave once every event is taken and the holdoff has run out.
                if (pending_d == 4'd0 && hold_d == 4'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new mask request always wins, even over the write that clears it.
        if (mask_wr_i) begin
            mask_d      = mask_i;
            mask_pend_d = 1'b1;
        end
    end

    // State registers and registered bus/event outputs.
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            state_q     <= ST_IDLE;
            init_pend_q <= 1'b1;
            pending_q   <= 4'd0;
            hold_q      <= 4'd0;
            mask_q      <= 4'd0;
            mask_pend_q <= 1'b0;
            rd_ce_q     <= 1'b0;
            wr_ce_q     <= 1'b0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            evt_valid_q <= 1'b0;
            evt_src_q   <= 2'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_pend_q <= init_pend_d;
            pending_q   <= pending_d;
            hold_q      <= hold_d;
            mask_q      <= mask_d;
            mask_pend_q <= mask_pend_d;
            rd_ce_q     <= (state_d == ST_RD_STAT);
            wr_ce_q     <= (state_d == ST_INIT_WR) || (state_d == ST_MASK_WR);
            case (state_d)
                ST_RD_STAT: begin
                    addr_q <= INT_BASE_ADDR;
                    data_q <= 32'd0;
                end
                ST_INIT_WR: begin
                    addr_q <= MASK_ADDR;
                    data_q <= {28'd0, MASK_INIT};
                end
                ST_MASK_WR: begin
                    addr_q <= MASK_ADDR;
                    data_q <= {28'd0, mask_d};
                end
                default: begin
                    addr_q <= 32'd0;
                    data_q <= 32'd0;
                end
            endcase
            evt_valid_q <= (state_d == ST_DISPATCH) && (pending_d != 4'd0);
            evt_src_q   <= (state_d == ST_DISPATCH) ? prio(pending_d) : 2'd0;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign ip2bus_addr_o  = addr_q;
    assign ip2bus_data_o  = data_q;
    assign ip2bus_rd_ce_o = rd_ce_q;
    assign ip2bus_wr_ce_o = wr_ce_q;
    assign evt_valid_o    = evt_valid_q;
    assign evt_src_o      = evt_src_q;
    assign busy_o         = busy_q;

`ifdef PTP_INT_SVC_STAT_EN
    logic [7:0]  spur_cnt_q;
    logic [15:0] evt_cnt_q;

    // Spurious-read counter saturates; accepted-event counter wraps.
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_rst) begin
            spur_cnt_q <= 8'd0;
            evt_cnt_q  <= 16'd0;
        end else begin
            if (spur_hit && spur_cnt_q != 8'hFF) spur_cnt_q <= spur_cnt_q + 8'd1;
            if (evt_acc)                         evt_cnt_q  <= evt_cnt_q + 16'd1;
        end
    end

    assign spur_cnt_o = spur_cnt_q;
    assign evt_cnt_o  = evt_cnt_q;
`else
    logic unused_stat;
    assign unused_stat = spur_hit ^ evt_acc;
    assign spur_cnt_o  = 8'd0;
    assign evt_cnt_o   = 16'd0;
`endif

endmodule

// File: tb/tb_ptp_int_svc.sv
// Directed bench for ptp_int_svc: reset, init write, dispatch ordering,
// backpressure, mask rewrite ordering, spurious reads, enable gating, reset abort.
module tb_ptp_int_svc;

`ifdef PTP_INT_SVC_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        int_ptp;
    logic        svc_en;
    logic [31:0] rd_data;
    logic [31:0] bus_rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_ce;
    logic        wr_ce;
    logic [3:0]  mask_in;
    logic        mask_wr;
    logic        evt_valid;
    logic [1:0]  evt_src;
    logic        evt_ready;
    logic        busy;
    logic [7:0]  spur_cnt;
    logic [15:0] evt_cnt;

    int vec;
    int err;

    ptp_int_svc dut (
        .bus2ip_clk     (clk),
        .bus2ip_rst     (rst),
        .int_ptp_i      (int_ptp),
        .svc_en_i       (svc_en),
        .bus2ip_data_i  (bus_rdata),
        .ip2bus_addr_o  (addr),
        .ip2bus_data_o  (wdata),
        .ip2bus_rd_ce_o (rd_ce),
        .ip2bus_wr_ce_o (wr_ce),
        .mask_i         (mask_in),
        .mask_wr_i      (mask_wr),
        .evt_valid_o    (evt_valid),
        .evt_src_o      (evt_src),
        .evt_ready_i    (evt_ready),
        .busy_o         (busy),
        .spur_cnt_o     (spur_cnt),
        .evt_cnt_o      (evt_cnt)
    );

    // Slave returns status only while the read strobe is up; otherwise junk in
    // the low nibble so a mistimed capture shows up as bogus events.
    assign bus_rdata = rd_ce ? rd_data : 32'h0000_000F;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vec = 0; err = 0;
        rst = 1'b1; int_ptp = 1'b0; svc_en = 1'b1; rd_data = 32'd0;
        mask_in = 4'd0; mask_wr = 1'b0; evt_ready = 1'b0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_rd_ce", 32'(rd_ce), 32'd0);
        chk("rst_wr_ce", 32'(wr_ce), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_data", wdata, 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_spur", 32'(spur_cnt), 32'd0);
        chk("rst_evtcnt", 32'(evt_cnt), 32'd0);

        // Initial mask write, exactly one cycle
        rst = 1'b0;
        tick();
        chk("init_wr_ce", 32'(wr_ce), 32'd1);
        chk("init_rd_ce", 32'(rd_ce), 32'd0);
        chk("init_addr", addr, 32'h301);
        chk("init_data", wdata, 32'h0000_000F);
        chk("init_busy", 32'(busy), 32'd1);
        tick();
        chk("post_init_wr_ce", 32'(wr_ce), 32'd0);
        chk("post_init_addr", addr, 32'd0);
        chk("post_init_data", wdata, 32'd0);
        chk("post_init_busy", 32'(busy), 32'd0);
        tick();
        chk("idle_strobes", {30'd0, rd_ce, wr_ce}, 32'd0);

        // Status 0x9 with ready high: src 3 then src 0 back to back
        rd_data = 32'h9; evt_ready = 1'b1; int_ptp = 1'b1;
        tick();
        chk("a_rd_ce", 32'(rd_ce), 32'd1);
        chk("a_rd_addr", addr, 32'h300);
        chk("a_rd_valid", 32'(evt_valid), 32'd0);
        int_ptp = 1'b0;
        tick();
        chk("a_t1_rd_ce", 32'(rd_ce), 32'd0);
        chk("a_t1_evt", {29'd0, evt_valid, evt_src}, {29'd0, 1'b1, 2'd3});
        tick();
        chk("a_t2_evt", {29'd0, evt_valid, evt_src}, {29'd0, 1'b1, 2'd0});
        tick();
        chk("a_t3_evt", {29'd0, evt_valid, evt_src}, 32'd0);
        for (int i = 3; i <= 6; i++) begin
            chk($sformatf("a_t%0d_busy", i), 32'(busy), 32'd1);
            tick();
        end
        chk("a_t7_busy", 32'(busy), 32'd0);

        // Status 0x2 with backpressure for 5 cycles
        rd_data = 32'h2; evt_ready = 1'b0; int_ptp = 1'b1;
        tick();
        chk("b_rd_ce", 32'(rd_ce), 32'd1);
        int_ptp = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("b_t%0d_hold", i), {29'd0, evt_valid, evt_src}, {29'd0, 1'b1, 2'd1});
        end
        tick();
        evt_ready = 1'b1;
        chk("b_t6_evt", {29'd0, evt_valid, evt_src}, {29'd0, 1'b1, 2'd1});
        tick();
        chk("b_t7_valid", 32'(evt_valid), 32'd0);
        chk("b_t7_busy", 32'(busy), 32'd0);

        // Mask write during dispatch with interrupt held: write precedes next read
        rd_data = 32'h2; int_ptp = 1'b1;
        tick();
        chk("c_rd_ce", 32'(rd_ce), 32'd1);
        tick();
        chk("c_t1_evt", {29'd0, evt_valid, evt_src}, {29'd0, 1'b1, 2'd1});
        mask_in = 4'h5; mask_wr = 1'b1;
        tick();
        mask_wr = 1'b0;
        chk("c_t2_busy", 32'(busy), 32'd1);
        tick(); tick(); tick(); tick();
        chk("c_t6_busy", 32'(busy), 32'd1);
        chk("c_t6_strobes", {30'd0, rd_ce, wr_ce}, 32'd0);
        tick();
        chk("c_t7_busy", 32'(busy), 32'd0);
        tick();
        chk("c_mwr_strobes", {30'd0, rd_ce, wr_ce}, 32'd1);
        chk("c_mwr_addr", addr, 32'h301);
        chk("c_mwr_data", wdata, 32'h5);
        tick();
        chk("c_t9_strobes", {30'd0, rd_ce, wr_ce}, 32'd0);
        tick();
        chk("c_rd2_ce", 32'(rd_ce), 32'd1);
        chk("c_rd2_addr", addr, 32'h300);
        int_ptp = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("c_drain_busy", 32'(busy), 32'd0);

        // Spurious status read
        rd_data = 32'h0; int_ptp = 1'b1;
        tick();
        chk("d_rd_ce", 32'(rd_ce), 32'd1);
        int_ptp = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("d_t%0d_valid", i), 32'(evt_valid), 32'd0);
        end
        chk("d_spur", 32'(spur_cnt), STAT ? 32'd1 : 32'd0);
        chk("d_evtcnt", 32'(evt_cnt), STAT ? 32'd5 : 32'd0);
        tick();
        chk("d_t7_busy", 32'(busy), 32'd0);

        // Service disabled: interrupt must not start a read
        svc_en = 1'b0; int_ptp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("e_blk%0d", i), {30'd0, rd_ce, busy}, 32'd0);
        end

        // Reset during dispatch with pending 0xC
        rd_data = 32'hC; evt_ready = 1'b0; svc_en = 1'b1;
        tick();
        chk("f_rd_ce", 32'(rd_ce), 32'd1);
        int_ptp = 1'b0;
        tick();
        chk("f_t1_evt", {29'd0, evt_valid, evt_src}, {29'd0, 1'b1, 2'd3});
        rst = 1'b1;
        tick();
        chk("f_rst_valid", 32'(evt_valid), 32'd0);
        chk("f_rst_busy", 32'(busy), 32'd0);
        chk("f_rst_evtcnt", 32'(evt_cnt), 32'd0);
        chk("f_rst_spur", 32'(spur_cnt), 32'd0);
        tick();
        rst = 1'b0; evt_ready = 1'b1;
        tick();
        chk("f_init_wr", {30'd0, rd_ce, wr_ce}, 32'd1);
        chk("f_init_data", wdata, 32'h0000_000F);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("f_stale%0d", i), {29'd0, evt_valid, busy, rd_ce}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
